// File: rtl/serial_uart_pkg.sv
// Shared definitions for the FIFO-buffered UART.
//   - TX and RX state encodings
//   - frame / data / counter widths
//   - pointer-width helper used by the FIFO
package serial_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_W   = 9;   // widest data payload (9-bit mode)
    localparam int RX_W     = 10;  // {stop bit, data[8:0]}
    localparam int PERIOD_W = 15;  // bit-time down-counter width
    localparam int BITIDX_W = 4;   // indexes data bits 0..8

    // Index of the final data bit for each frame length.
    localparam logic [BITIDX_W-1:0] LAST_BIT_8 = 4'd7;
    localparam logic [BITIDX_W-1:0] LAST_BIT_9 = 4'd8;

    // Pointer width for a power-of-two FIFO of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/serial_uart_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en           qualifies every state update
//   wr, wdata    push request and data
//   rd           pop request (ignored when empty)
//   rdata        current head, zero while empty
//   empty, full  occupancy flags
// A push while full is accepted only when a pop happens on the same cycle.
module serial_uart_fifo
    import serial_uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int            PW         = ptr_width(DEPTH);
    localparam logic [PW:0]   COUNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == COUNT_FULL);
    assign w_do_rd = en & rd & ~empty;
    assign w_do_wr = en & wr & (~full | w_do_rd);

    // Head must be visible combinationally so the consumer can see it
    // in the same cycle the entry becomes available.
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_do_wr) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serial_fifo_uart.sv
// FIFO-buffered UART: TX FIFO feeding a serialiser, deserialiser feeding
// an RX FIFO. Frame = start 0, 8 or 9 data bits LSB first, one stop 1.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clk_en             qualifies every non-reset state update
//   period             bit time minus one, in clk_en cycles
//   long               1 = 9 data bits, 0 = 8 data bits
//   brk                forces txd low (TX FSM keeps running)
//   tx_wr, tx_data     push into TX FIFO; tx_full, tx_idle status
//   rx_rd              pop RX FIFO head
//   rx_data            RX head {stop bit, data[8:0]}
//   rx_valid, rx_ovrun RX not empty; sticky overrun
//   txint, rxint       one-clk_en-cycle event pulses
//   txd, rxd           serial line, idle high
module serial_fifo_uart
    import serial_uart_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                long,
    input  logic                brk,
    input  logic                tx_wr,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                tx_full,
    output logic                tx_idle,
    input  logic                rx_rd,
    output logic [RX_W-1:0]     rx_data,
    output logic                rx_valid,
    output logic                rx_ovrun,
    output logic                txint,
    output logic                rxint,
    output logic                txd,
    input  logic                rxd
);

    // ---------------- TX path ----------------
    tx_state_t              r_tx_state;
    logic [PERIOD_W-1:0]    r_tx_cnt;
    logic [BITIDX_W-1:0]    r_tx_bit;
    logic [DATA_W-1:0]      r_tx_shift;
    logic                   r_tx_long;
    logic                   r_txd;
    logic                   r_txint;

    logic                   w_tx_empty;
    logic [DATA_W-1:0]      w_tx_head;
    logic                   w_tx_pop;
    logic                   w_tx_push;
    logic                   w_tx_cnt_zero;
    logic [BITIDX_W-1:0]    w_tx_last;

    assign w_tx_cnt_zero = (r_tx_cnt == '0);
    assign w_tx_last     = r_tx_long ? LAST_BIT_9 : LAST_BIT_8;
    // Pop from IDLE, or on the last STOP cycle so frames run back-to-back.
    assign w_tx_pop      = clk_en & ~w_tx_empty &
                           ((r_tx_state == TX_IDLE) |
                            ((r_tx_state == TX_STOP) & w_tx_cnt_zero));
    // A write while full is dropped even if a pop frees space this cycle.
    assign w_tx_push     = tx_wr & ~tx_full;

    serial_uart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .wr    (w_tx_push),
        .wdata (tx_data),
        .rd    (w_tx_pop),
        .rdata (w_tx_head),
        .empty (w_tx_empty),
        .full  (tx_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_long  <= 1'b0;
            r_txd      <= 1'b1;
            r_txint    <= 1'b0;
        end else if (clk_en) begin
            r_txint <= 1'b0;
            if (w_tx_pop) begin
                r_tx_state <= TX_START;
                r_tx_cnt   <= period;
                r_tx_shift <= w_tx_head;
                r_tx_long  <= long;
                r_txd      <= 1'b0;
                r_txint    <= 1'b1;
            end else if (r_tx_state != TX_IDLE && !w_tx_cnt_zero) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_tx_cnt   <= period;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                    end
                    TX_DATA: begin
                        r_tx_cnt <= period;
                        if (r_tx_bit == w_tx_last) begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                        end
                    end
                    TX_STOP: r_tx_state <= TX_IDLE;
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign txd     = r_txd & ~brk;
    assign tx_idle = w_tx_empty & (r_tx_state == TX_IDLE);
    assign txint   = r_txint;

    // ---------------- RX path ----------------
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    rx_state_t              r_rx_state;
    logic [PERIOD_W-1:0]    r_rx_cnt;
    logic [BITIDX_W-1:0]    r_rx_bit;
    logic [DATA_W-1:0]      r_rx_shift;
    logic                   r_rx_long;
    logic                   r_rxint;
    logic                   r_ovrun;

    logic                   w_rx_cnt_zero;
    logic                   w_rx_fall;
    logic                   w_rx_store;
    logic                   w_rx_drop;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic [RX_W-1:0]        w_rx_word;
    logic [BITIDX_W-1:0]    w_rx_last;

    assign w_rx_cnt_zero = (r_rx_cnt == '0);
    assign w_rx_fall     = r_rx_prev & ~r_sync2;
    assign w_rx_last     = r_rx_long ? LAST_BIT_9 : LAST_BIT_8;
    assign w_rx_store    = clk_en & (r_rx_state == RX_STOP) & w_rx_cnt_zero;
    // Bit 8 is stale from an earlier 9-bit frame in 8-bit mode; mask it.
    assign w_rx_word     = {r_sync2, r_rx_long & r_rx_shift[8], r_rx_shift[7:0]};
    // A simultaneous read frees the slot, so only an unread full FIFO drops.
    assign w_rx_drop     = w_rx_store & w_rx_full & ~rx_rd;

    serial_uart_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .wr    (w_rx_store),
        .wdata (w_rx_word),
        .rd    (rx_rd),
        .rdata (rx_data),
        .empty (w_rx_empty),
        .full  (w_rx_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_long  <= 1'b0;
            r_rxint    <= 1'b0;
            r_ovrun    <= 1'b0;
        end else if (clk_en) begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_rxint   <= w_rx_store;

            // Set has priority over the clear from a read.
            if (w_rx_drop)
                r_ovrun <= 1'b1;
            else if (rx_rd && !w_rx_empty)
                r_ovrun <= 1'b0;

            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        // Half a bit time puts the samples mid-bit.
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= {1'b0, period[PERIOD_W-1:1]};
                        r_rx_long  <= long;
                    end
                end
                RX_START: begin
                    if (!w_rx_cnt_zero) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else if (!r_sync2) begin
                        r_rx_state <= RX_DATA;
                        r_rx_cnt   <= period;
                        r_rx_bit   <= '0;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!w_rx_cnt_zero) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else begin
                        r_rx_shift[r_rx_bit] <= r_sync2;
                        r_rx_cnt             <= period;
                        if (r_rx_bit == w_rx_last)
                            r_rx_state <= RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (!w_rx_cnt_zero)
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    else
                        r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid = ~w_rx_empty;
    assign rx_ovrun = r_ovrun;
    assign rxint    = r_rxint;

endmodule
